jpeg_bitstream_packer: RTL and testbench
========================================

// Module: jpeg_bitstream_packer
// PURPOSE
//   Consumer of jpeg_huffman_encode's variable-length code stream (output_wren/length/data).
//   Concatenates codes MSB-first into bytes, applies JPEG byte stuffing (0xFF -> 0xFF 0x00)
//   and pads the final partial byte with 1s on flush. Produces a valid/ready byte stream
//   for the SPI/frame writer. Backpressures the encoder through in_ready (drives its stall).
// PARAMETERS
//   BUF_BITS      64  bit accumulator width; must be >= 40
//   STUFF_ENABLE  1   1 = insert 0x00 after every emitted 0xFF; 0 = raw bytes
//   PAD_BIT       1   value of fill bits used to complete the last byte on flush
// PORTS
//   clock         in   1   single clock; all logic on rising edge
//   reset         in   1   synchronous, active-high
//   input_wren    in   1   code word present this cycle
//   input_length  in   6   number of valid bits, 0..32
//   input_data    in   32  code bits, right-aligned; bit [len-1] is emitted first
//   flush         in   1   pulse: pad to byte boundary and drain everything
//   in_ready      out  1   packer can accept a word (and flush) this cycle
//   output_valid  out  1   output_byte holds a byte
//   output_byte   out  8   next stream byte
//   output_ready  in   1   downstream accepts byte when output_valid & output_ready
//   flush_done    out  1   one-cycle pulse when flush fully drained
//   overflow      out  1   sticky: a word/flush arrived while in_ready was low
// BEHAVIOUR
//   Reset: bit_count=0, stuff_pending=0, state=RUN; output_valid=0, output_byte=0x00,
//     flush_done=0, overflow=0, in_ready=1. Reset mid-stream discards all pending bits.
//   Accumulator: bit_buf holds bit_count bits, oldest bit at the top of the valid region.
//     Accept when input_wren & in_ready: append input_data[len-1:0]; len=0 is a no-op.
//     len > 32 clamped to 32.
//   in_ready = (state==RUN) & (bit_count <= BUF_BITS-32). Combinational from registers only.
//   Write while !in_ready: word dropped, overflow<=1 (cleared only by reset). Same for flush.
//   Output register: loaded when (!output_valid | output_ready). Priority of the load:
//     1) stuff_pending -> byte 0x00, clear stuff_pending;
//     2) bit_count >= 8 -> top 8 bits, bit_count -= 8; if byte==0xFF & STUFF_ENABLE,
//        set stuff_pending;
//     3) else output_valid<=0.
//   Append and extract in the same cycle: bit_count_next = bit_count + len - 8.
//   Latency: word accepted on edge E, output register free -> its first byte valid after
//     edge E+1. Throughput 1 byte/cycle while output_ready=1.
//   output_byte stable while output_valid & !output_ready.
//   FSM: RUN -> (flush accepted) PAD -> DRAIN -> RUN.
//     flush with input_wren same cycle: word appended first, then padded.
//     PAD (1 cycle): if bit_count%8 != 0 append (8 - bit_count%8) PAD_BIT bits.
//     DRAIN: in_ready=0; wait until bit_count==0, stuff_pending==0 and output register
//       empty or consumed this cycle; then flush_done=1 for one cycle, return to RUN.
//     Flush with empty buffer: PAD, DRAIN, flush_done 2 cycles after flush accepted.
//   Padding bits are stuffed like any other bits (e.g. final byte 0xFF -> 0xFF 0x00).
// TESTING
//   1) len3 0b101, then len5 0b11111 -> single byte 0xBF; no further output_valid.
//   2) len8 0xFF, len8 0x12 -> bytes FF 00 12 in order; STUFF_ENABLE=0 -> FF 12.
//   3) len1 0b0, flush -> byte 0x7F, flush_done pulse once; len4 0xF, flush -> FF 00.
//   4) output_ready=0 for 20 cycles while writing len32 0x12345678 continuously ->
//      in_ready drops when bit_count>32; on release bytes 12 34 56 78 12 34 56 78 ..., none lost.
//   5) input_wren with in_ready=0 -> word absent from stream, overflow=1 until reset.
//   6) 13 pending bits + output_valid high, assert reset -> next cycle output_valid=0,
//      in_ready=1, overflow=0; write len8 0xA5 -> only byte A5 emitted.

Source files
------------

// File: rtl/jpeg_bitstream_packer.sv
// Packs variable-length JPEG code words MSB-first into bytes with 0xFF byte stuffing
// and 1-padding on flush; emits a valid/ready byte stream and stalls the encoder.
module jpeg_bitstream_packer #(
  parameter int BUF_BITS     = 64,
  parameter bit STUFF_ENABLE = 1'b1,
  parameter bit PAD_BIT      = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        input_wren,
  input  logic [5:0]  input_length,
  input  logic [31:0] input_data,
  input  logic        flush,
  output logic        in_ready,
  output logic        output_valid,
  output logic [7:0]  output_byte,
  input  logic        output_ready,
  output logic        flush_done,
  output logic        overflow,
  output logic [1:0]  o_dbg_state
);

  localparam int CW = $clog2(BUF_BITS + 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_PAD   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Handshakes: a code word (or flush) is taken on a rising edge where it is
  // presented while in_ready is high; a byte is taken on a rising edge where
  // output_valid & output_ready, and output_byte holds still until then.

  state_t              r_state;
  logic [BUF_BITS-1:0] r_bit_buf;
  logic [CW-1:0]       r_bit_count;
  logic                r_stuff_pending;
  logic                r_output_valid;
  logic [7:0]          r_output_byte;
  logic                r_flush_done;
  logic                r_overflow;

  logic [5:0]          w_len;
  logic                w_in_ready;
  logic                w_accept_word;
  logic                w_accept_flush;
  logic                w_load;
  logic                w_take;
  logic [7:0]          w_top_byte;
  logic [CW-1:0]       w_count_base;
  logic [2:0]          w_pad_len;
  logic [5:0]          w_add_len;
  logic [BUF_BITS-1:0] w_add_bits;
  logic                w_drain_done;

  assign w_len          = (input_length > 6'd32) ? 6'd32 : input_length;
  assign w_in_ready     = (r_state == S_RUN) && (r_bit_count <= CW'(BUF_BITS - 32));
  assign w_accept_word  = input_wren & w_in_ready;
  assign w_accept_flush = flush & w_in_ready;

  // The buffer is right-aligned: the oldest bit sits at index bit_count-1.
  assign w_load       = !r_output_valid | output_ready;
  assign w_take       = w_load & !r_stuff_pending & (r_bit_count >= CW'(8));
  assign w_top_byte   = 8'(r_bit_buf >> (r_bit_count - CW'(8)));
  assign w_count_base = r_bit_count - (w_take ? CW'(8) : CW'(0));
  assign w_pad_len    = 3'd0 - w_count_base[2:0];

  always_comb begin
    w_add_len  = 6'd0;
    w_add_bits = '0;
    if (w_accept_word) begin
      w_add_len  = w_len;
      w_add_bits = {{(BUF_BITS-32){1'b0}}, input_data} & ~({BUF_BITS{1'b1}} << w_len);
    end else if (r_state == S_PAD) begin
      w_add_len  = {3'b000, w_pad_len};
      w_add_bits = PAD_BIT ? ~({BUF_BITS{1'b1}} << w_pad_len) : '0;
    end
  end

  assign w_drain_done = (r_state == S_DRAIN) && (r_bit_count == '0) &&
                        !r_stuff_pending && w_load;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= S_RUN;
      r_bit_buf       <= '0;
      r_bit_count     <= '0;
      r_stuff_pending <= 1'b0;
      r_output_valid  <= 1'b0;
      r_output_byte   <= 8'h00;
      r_flush_done    <= 1'b0;
      r_overflow      <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      if ((input_wren | flush) & !w_in_ready) r_overflow <= 1'b1;

      if (w_load) begin
        if (r_stuff_pending) begin
          r_output_byte   <= 8'h00;
          r_output_valid  <= 1'b1;
          r_stuff_pending <= 1'b0;
        end else if (w_take) begin
          r_output_byte  <= w_top_byte;
          r_output_valid <= 1'b1;
          if (STUFF_ENABLE && (w_top_byte == 8'hFF)) r_stuff_pending <= 1'b1;
        end else begin
          r_output_valid <= 1'b0;
        end
      end

      r_bit_buf   <= (r_bit_buf << w_add_len) | w_add_bits;
      r_bit_count <= w_count_base + CW'(w_add_len);

      case (r_state)
        S_RUN:   if (w_accept_flush) r_state <= S_PAD;
        S_PAD:   r_state <= S_DRAIN;
        S_DRAIN: begin
          if (w_drain_done) begin
            r_flush_done <= 1'b1;
            r_state      <= S_RUN;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign in_ready     = w_in_ready;
  assign output_valid = r_output_valid;
  assign output_byte  = r_output_byte;
  assign flush_done   = r_flush_done;
  assign overflow     = r_overflow;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_jpeg_bitstream_packer.sv
// Bench for jpeg_bitstream_packer: bit-queue reference model feeding an expected-byte
// scoreboard, with a free-running output monitor.
module tb_jpeg_bitstream_packer;
  localparam bit STUFF = 1'b1;
  localparam bit PAD   = 1'b1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        input_wren = 1'b0;
  logic [5:0]  input_length = '0;
  logic [31:0] input_data = '0;
  logic        flush = 1'b0;
  logic        output_ready = 1'b0;
  logic        in_ready, output_valid, flush_done, overflow;
  logic [7:0]  output_byte;
  logic [1:0]  dbg_state;

  jpeg_bitstream_packer #(.BUF_BITS(64), .STUFF_ENABLE(STUFF), .PAD_BIT(PAD)) dut (
    .clock(clock), .reset(reset), .input_wren(input_wren), .input_length(input_length),
    .input_data(input_data), .flush(flush), .in_ready(in_ready),
    .output_valid(output_valid), .output_byte(output_byte), .output_ready(output_ready),
    .flush_done(flush_done), .overflow(overflow), .o_dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  bit         mdl_bits[$];
  int         exp_fd = 0;
  int         fd_seen = 0;
  logic       exp_ovf = 1'b0;
  int         rdy_pct = 100;
  int         acc_words = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain bit queue, bytes cut 8 bits at a time.
  function automatic void mdl_emit();
    while (mdl_bits.size() >= 8) begin
      logic [7:0] b;
      b = '0;
      for (int i = 0; i < 8; i++) b = {b[6:0], mdl_bits.pop_front()};
      exp_q.push_back(b);
      if (STUFF && b == 8'hFF) exp_q.push_back(8'h00);
    end
  endfunction

  function automatic void mdl_word(input int len, input logic [31:0] d);
    int l;
    l = (len > 32) ? 32 : len;
    for (int i = l - 1; i >= 0; i--) mdl_bits.push_back(d[i]);
    mdl_emit();
  endfunction

  function automatic void mdl_flush();
    while (mdl_bits.size() % 8 != 0) mdl_bits.push_back(PAD);
    mdl_emit();
  endfunction

  // One cycle of stimulus; honor=1 behaves like a stalled encoder.
  task automatic step(input bit wr, input int len, input logic [31:0] d, input bit fl,
                      input bit honor);
    bit ok;
    @(negedge clock);
    ok = in_ready;
    if (honor && !ok) begin
      wr = 1'b0;
      fl = 1'b0;
    end
    input_wren   = wr;
    input_length = 6'(len);
    input_data   = d;
    flush        = fl;
    if (wr) begin
      if (ok) begin
        mdl_word(len, d);
        acc_words++;
      end else exp_ovf = 1'b1;
    end
    if (fl) begin
      if (ok) begin
        mdl_flush();
        exp_fd++;
      end else exp_ovf = 1'b1;
    end
  endtask

  task automatic idle();
    step(1'b0, 0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && fd_seen == exp_fd && !output_valid && in_ready) && k < 600) begin
      idle();
      k++;
    end
    repeat (4) idle();
    chk({name, "_drained"}, exp_q.size(), 0);
    chk({name, "_flush_done_count"}, fd_seen, exp_fd);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    #2;
    reset      = 1'b1;
    input_wren = 1'b0;
    flush      = 1'b0;
    exp_q.delete();
    mdl_bits.delete();
    exp_ovf    = 1'b0;
    @(negedge clock);
    #2 reset = 1'b0;
  endtask

  // Monitor: picks this cycle's output_ready, then scores any byte taken at the next edge.
  logic       hold_v = 1'b0;
  logic [7:0] hold_b = '0;
  always @(negedge clock) begin
    output_ready = ($urandom_range(0, 99) < rdy_pct);
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (flush_done) fd_seen++;
      if (hold_v) begin
        chk("hold_valid", output_valid, 1);
        chk("hold_byte", output_byte, hold_b);
      end
      if (output_valid && output_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_byte: got %0h expected none (t=%0t)", output_byte, $time);
        end else begin
          chk("byte", output_byte, exp_q.pop_front());
        end
      end
      hold_v = output_valid && !output_ready;
      hold_b = output_byte;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    bit wr, fl, honor;
    int len, fd_before;
    logic [31:0] d;
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    chk("rst_valid", output_valid, 0);
    chk("rst_byte", output_byte, 8'h00);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_overflow", overflow, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_state", dbg_state, 0);

    // Two codes forming exactly one byte; stuffing pair; flush padding.
    step(1'b1, 3, 32'h5, 1'b0, 1'b1);
    step(1'b1, 5, 32'h1F, 1'b0, 1'b1);
    wait_idle("t1");
    step(1'b1, 8, 32'hFF, 1'b0, 1'b1);
    step(1'b1, 8, 32'h12, 1'b0, 1'b1);
    wait_idle("t2");
    step(1'b1, 1, 32'h0, 1'b0, 1'b1);
    step(1'b0, 0, 32'h0, 1'b1, 1'b1);
    wait_idle("t3a");
    step(1'b1, 4, 32'hF, 1'b1, 1'b1);
    wait_idle("t3b");

    // Empty flush: flush_done exactly two cycles after acceptance.
    step(1'b0, 0, 32'h0, 1'b1, 1'b1);
    idle();
    chk("empty_flush_fd_e1", flush_done, 0);
    idle();
    chk("empty_flush_fd_e2", flush_done, 0);
    idle();
    chk("empty_flush_fd_e3", flush_done, 1);
    idle();
    chk("empty_flush_fd_e4", flush_done, 0);
    wait_idle("t_empty");

    // Output stalled while the encoder keeps offering 32-bit words.
    rdy_pct = 0;
    idle();
    idle();
    acc_words = 0;
    for (int i = 0; i < 20; i++) step(1'b1, 32, 32'h12345678, 1'b0, 1'b1);
    chk("t4_words_accepted", acc_words, 2);
    chk("t4_in_ready_low", in_ready, 0);
    chk("t4_valid_held", output_valid, 1);
    rdy_pct = 100;
    wait_idle("t4");

    // Writes and flushes ignoring in_ready are dropped and flagged.
    chk("t5_overflow_before", overflow, 0);
    rdy_pct = 0;
    idle();
    idle();
    for (int i = 0; i < 3; i++) step(1'b1, 32, 32'hCAFEF00D, 1'b0, 1'b1);
    step(1'b1, 8, 32'h55, 1'b0, 1'b0);
    step(1'b0, 0, 32'h0, 1'b1, 1'b0);
    idle();
    chk("t5_overflow_set", overflow, exp_ovf);
    rdy_pct = 100;
    wait_idle("t5");
    chk("t5_overflow_sticky", overflow, 1);

    // Reset mid-stream discards everything pending.
    rdy_pct = 0;
    idle();
    idle();
    step(1'b1, 8, 32'h3C, 1'b0, 1'b1);
    step(1'b1, 5, 32'h15, 1'b0, 1'b1);
    idle();
    idle();
    chk("t6_valid_pre", output_valid, 1);
    pulse_reset();
    @(negedge clock);
    chk("t6_valid_post", output_valid, 0);
    chk("t6_in_ready_post", in_ready, 1);
    chk("t6_overflow_post", overflow, 0);
    rdy_pct = 100;
    step(1'b1, 8, 32'hA5, 1'b0, 1'b1);
    wait_idle("t6");

    // Random traffic with random backpressure, flushes and occasional stall violations.
    rdy_pct = 60;
    for (int i = 0; i < 400; i++) begin
      wr    = ($urandom_range(0, 9) < 7);
      len   = ($urandom_range(0, 19) == 0) ? $urandom_range(33, 63) : $urandom_range(0, 32);
      d     = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      fl    = ($urandom_range(0, 49) == 0);
      honor = ($urandom_range(0, 19) != 0);
      step(wr, len, d, fl, honor);
    end
    fd_before = exp_fd;
    for (int k = 0; k < 300 && exp_fd == fd_before; k++) step(1'b0, 0, 32'h0, 1'b1, 1'b1);
    chk("rand_final_flush_taken", exp_fd, fd_before + 1);
    wait_idle("rand");
    chk("rand_overflow", overflow, exp_ovf);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
